alu_arbiter: RTL and testbench

//   Shares one combinational ALU (3-bit ALUControl) between two requesters, e.g. a core EX stage and a debug/DMA port.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_arbiter_if.sv | 54 +++++
 rtl/rr_arb2.sv | 15 +
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, FSM encoding and requester id type
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int ID_W = 1;
    typedef logic [ID_W-1:0] id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Only the four basic codes are implemented by the external ALU; 1xx is rejected.
    function automatic logic ctrl_supported(input logic [2:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_AND) || (ctrl == ALU_OR);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response/ALU bundle between requesters and the arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_ctrl;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_ctrl;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result,
        input  busy
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant selection
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        gnt_valid_o = |valid_i;
        gnt_id_o    = (&valid_i) ? ptr_i : valid_i[1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;
    id_t              id_q;
    logic             rr_ptr_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic             busy_q;

    logic             gnt_valid;
    logic             gnt_id;
    logic             accept;
    logic             rsp_hs;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [2:0]       ctrl_d;
    id_t              id_d;
    logic             err_d;
    logic [WIDTH-1:0] result_d;

    rr_arb2 u_rr_arb2 (
        .valid_i     ({bus.req1_valid, bus.req0_valid}),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // Grant, operand select and result qualification; ready is held low while in reset.
    always_comb begin
        accept   = (state_q == ST_IDLE) && !reset && gnt_valid;
        rsp_hs   = (rsp0_valid_q && bus.rsp0_ready) || (rsp1_valid_q && bus.rsp1_ready);
        a_d      = gnt_id ? bus.req1_a : bus.req0_a;
        b_d      = gnt_id ? bus.req1_b : bus.req0_b;
        ctrl_d   = gnt_id ? bus.req1_ctrl : bus.req0_ctrl;
        id_d     = id_t'(gnt_id);
        err_d    = !ctrl_supported(ctrl_q);
        result_d = err_d ? '0 : bus.alu_result;
    end

    assign bus.req0_ready = accept && !gnt_id;
    assign bus.req1_ready = accept && gnt_id;

    // The ALU only sees captured operands during EXEC so it idles at zero otherwise.
    always_comb begin
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = '0;
        if (state_q == ST_EXEC) begin
            bus.alu_a    = a_q;
            bus.alu_b    = b_q;
            bus.alu_ctrl = ctrl_q;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = busy_q;

    // Request capture, ALU result register and response hold; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= '0;
            id_q         <= '0;
            rr_ptr_q     <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        ctrl_q  <= ctrl_d;
                        id_q    <= id_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q     <= result_d;
                    zero_q       <= (result_d == '0);
                    err_q        <= err_d;
                    rsp0_valid_q <= (id_q == id_t'(0));
                    rsp1_valid_q <= (id_q == id_t'(1));
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        rr_ptr_q     <= ~id_q;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic         v   [2];
    logic [W-1:0] ta  [2];
    logic [W-1:0] tbv [2];
    logic [2:0]   tc  [2];
    logic         r   [2];

    assign bus.req0_valid = v[0];
    assign bus.req0_a     = ta[0];
    assign bus.req0_b     = tbv[0];
    assign bus.req0_ctrl  = tc[0];
    assign bus.req1_valid = v[1];
    assign bus.req1_a     = ta[1];
    assign bus.req1_b     = tbv[1];
    assign bus.req1_ctrl  = tc[1];
    assign bus.rsp0_ready = r[0];
    assign bus.rsp1_ready = r[1];

    // External ALU stand-in; unsupported codes produce junk the arbiter must suppress.
    function automatic logic [W-1:0] ext_alu(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return 32'hDEAD_BEEF ^ a;
        endcase
    endfunction
    assign bus.alu_result = ext_alu(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the opcode table: modular add/sub, bitwise and/or, 1xx yields 0.
    function automatic logic [W-1:0] ref_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned s;
        if (c[2]) return '0;
        case (c[1:0])
            2'd0: begin s = longint'(a) + longint'(b); return s[W-1:0]; end
            2'd1: begin s = (longint'(1) << W) + longint'(a) - longint'(b); return s[W-1:0]; end
            2'd2: return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic ready_of(input int id);
        return (id == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    // Transaction-level model: one op in flight, response two cycles after its handshake.
    bit           pend = 0;
    int           pend_id = 0;
    logic [W-1:0] pend_a, pend_b, pend_res;
    logic [2:0]   pend_c;
    bit           pend_err;
    int           hs_cyc = 0;
    int           cyc = 0;
    int           owed = 0;
    logic [W+1:0] log0[$];
    logic [W+1:0] log1[$];
    int           order_q[$];

    initial begin
        int  gnt;
        bit  rsp_ph, exec_ph, s_rst, s_r0, s_r1;
        logic [W-1:0] s_a, s_b;
        logic [2:0]   s_c;
        forever begin
            @(negedge clk);
            gnt = -1;
            if (!pend && !reset) begin
                if (v[0] && v[1]) gnt = owed;
                else if (v[0])    gnt = 0;
                else if (v[1])    gnt = 1;
            end
            rsp_ph  = pend && (cyc >= hs_cyc + 2);
            exec_ph = pend && (cyc == hs_cyc + 1);
            check("req0_ready", bus.req0_ready, gnt == 0);
            check("req1_ready", bus.req1_ready, gnt == 1);
            check("busy", bus.busy, pend);
            check("rsp0_valid", bus.rsp0_valid, rsp_ph && pend_id == 0);
            check("rsp1_valid", bus.rsp1_valid, rsp_ph && pend_id == 1);
            if (rsp_ph) begin
                check("rsp_result", bus.rsp_result, pend_res);
                check("rsp_zero", bus.rsp_zero, pend_res == '0);
                check("rsp_err", bus.rsp_err, pend_err);
            end
            check("alu_a", bus.alu_a, exec_ph ? pend_a : '0);
            check("alu_b", bus.alu_b, exec_ph ? pend_b : '0);
            check("alu_ctrl", bus.alu_ctrl, exec_ph ? pend_c : 3'd0);
            s_rst = reset;
            s_r0  = r[0];
            s_r1  = r[1];
            if (gnt >= 0) begin
                s_a = ta[gnt];
                s_b = tbv[gnt];
                s_c = tc[gnt];
            end
            if (rsp_ph && ((pend_id == 0) ? s_r0 : s_r1) && !s_rst) begin
                if (pend_id == 0) log0.push_back({bus.rsp_err, bus.rsp_zero, bus.rsp_result});
                else              log1.push_back({bus.rsp_err, bus.rsp_zero, bus.rsp_result});
            end
            @(posedge clk);
            if (s_rst) begin
                pend = 0;
                owed = 0;
            end else if (rsp_ph && ((pend_id == 0) ? s_r0 : s_r1)) begin
                pend = 0;
                owed = 1 - pend_id;
            end else if (gnt >= 0) begin
                pend     = 1;
                pend_id  = gnt;
                pend_a   = s_a;
                pend_b   = s_b;
                pend_c   = s_c;
                pend_err = s_c[2];
                pend_res = ref_op(s_c, s_a, s_b);
                hs_cyc   = cyc;
            end
            cyc++;
        end
    end

    bit auto_rdy = 1;
    bit rand_rdy = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_rdy) begin
                r[0] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                r[1] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Present one op and hold it until accepted; call aligned to posedge+1, returns at posedge+1.
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
        bit got;
        got     = 0;
        v[id]   = 1'b1;
        ta[id]  = a;
        tbv[id] = b;
        tc[id]  = c;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready_of(id)) begin
                got = 1;
                break;
            end
        end
        if (!got) check("issue_timeout", 0, 1);
        else order_q.push_back(id);
        @(posedge clk);
        #1;
        v[id] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_check(input int id, input string name, input logic [W+1:0] exp);
        logic [W+1:0] got;
        if (id == 0) begin
            if (log0.size() == 0) begin check({name, "_missing"}, 0, 1); return; end
            got = log0.pop_front();
        end else begin
            if (log1.size() == 0) begin check({name, "_missing"}, 0, 1); return; end
            got = log1.pop_front();
        end
        check({name, "_result"}, got[W-1:0], exp[W-1:0]);
        check({name, "_zero"}, W'(got[W]), W'(exp[W]));
        check({name, "_err"}, W'(got[W+1]), W'(exp[W+1]));
    endtask

    task automatic rand_thread(input int id, input int n);
        logic [W-1:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            if ($urandom_range(0, 5) == 0) begin a = '1; b = 32'h1; end
            issue(id, a, b, 3'($urandom_range(0, 7)));
            idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        int n;
        logic [W-1:0] held_res;
        logic         held_zero;
        v[0] = 0; v[1] = 0;
        ta[0] = '0; ta[1] = '0; tbv[0] = '0; tbv[1] = '0; tc[0] = '0; tc[1] = '0;
        r[0] = 1; r[1] = 1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_rsp0_valid", bus.rsp0_valid, 0);
        check("reset_rsp1_valid", bus.rsp1_valid, 0);
        check("reset_result", bus.rsp_result, 0);
        check("reset_alu_a", bus.alu_a, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // Contention straight after reset: req0 wins, then req1.
        fork
            issue(0, 32'd5, 32'd3, ALU_SUB);
            issue(1, 32'h0000_000F, 32'h0000_0008, ALU_AND);
        join
        idle(4);
        check("t2_first", order_q[0], 0);
        check("t2_second", order_q[1], 1);
        pop_check(0, "t2_sub", {2'b00, 32'd2});
        pop_check(1, "t2_and", {2'b00, 32'd8});

        // Simple add with latency measured from the handshake.
        issue(0, 32'd3, 32'd1, ALU_ADD);
        n = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rsp0_valid) break;
            n++;
        end
        check("t1_latency", n, 2);
        idle(2);
        pop_check(0, "t1_add", {2'b00, 32'h4});

        // Backpressure on rsp0 while req1 waits.
        auto_rdy = 0;
        r[0] = 0;
        r[1] = 1;
        issue(0, 32'h0000_0010, 32'h0000_0010, ALU_SUB);
        v[1] = 1; ta[1] = 32'h0000_00F0; tbv[1] = 32'h0000_000F; tc[1] = ALU_OR;
        @(negedge clk);
        check("t3_ready1_exec", bus.req1_ready, 0);
        @(negedge clk);
        held_res  = bus.rsp_result;
        held_zero = bus.rsp_zero;
        check("t3_res_zero_lit", held_res, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check("t3_valid_held", bus.rsp0_valid, 1);
            check("t3_result_held", bus.rsp_result, held_res);
            check("t3_zero_held", bus.rsp_zero, held_zero);
            check("t3_ready1_blocked", bus.req1_ready, 0);
        end
        @(posedge clk);
        #1 r[0] = 1;
        @(negedge clk);
        check("t3_ready1_pre_hs", bus.req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("t3_ready1_after_hs", bus.req1_ready, 1);
        @(posedge clk);
        #1 v[1] = 0;
        auto_rdy = 1;
        idle(4);
        pop_check(0, "t3_sub", {2'b01, 32'h0});
        pop_check(1, "t3_or", {2'b00, 32'h0000_00FF});

        // Zero and wrap-around cases, plus an unsupported code.
        issue(0, 32'hF000_00FF, 32'hF000_00FF, ALU_SUB);
        idle(3);
        issue(1, 32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD);
        idle(3);
        issue(0, 32'h1234_5678, 32'h0000_0001, 3'b100);
        idle(3);
        pop_check(0, "t4_sub_zero", {2'b01, 32'h0});
        pop_check(1, "t4_add_wrap", {2'b01, 32'h0});
        pop_check(0, "t4_unsup", {2'b11, 32'h0});

        // Fairness: last served was req0, so serve a lone req1 to hand priority back to req0.
        issue(1, 32'd7, 32'd9, ALU_ADD);
        idle(3);
        pop_check(1, "t5_pre", {2'b00, 32'd16});
        order_q.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) issue(0, W'(i), 32'd100, ALU_ADD);
            end
            begin
                for (int i = 0; i < 3; i++) issue(1, 32'd50, W'(i), ALU_SUB);
            end
        join
        idle(4);
        check("t5_count", order_q.size(), 6);
        for (int i = 0; i < 6 && i < order_q.size(); i++) check("t5_order", order_q[i], i % 2);
        for (int i = 0; i < 3; i++) pop_check(0, "t5_r0", {2'b00, 32'd100 + W'(i)});
        for (int i = 0; i < 3; i++) pop_check(1, "t5_r1", {2'b00, 32'd50 - W'(i)});

        // Reset during EXEC: priority is first moved to req1 by serving req0.
        issue(0, 32'd1, 32'd1, ALU_ADD);
        idle(3);
        pop_check(0, "t6_pre", {2'b00, 32'd2});
        issue(0, 32'd8, 32'd9, ALU_ADD);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_busy", bus.busy, 0);
        check("t6_rsp0", bus.rsp0_valid, 0);
        idle(4);
        check("t6_no_rsp", log0.size(), 0);
        order_q.delete();
        fork
            issue(0, 32'd20, 32'd22, ALU_ADD);
            issue(1, 32'hFF00_FF00, 32'h0F0F_0F0F, ALU_AND);
        join
        idle(4);
        check("t6_req0_first", order_q[0], 0);
        pop_check(0, "t6_add", {2'b00, 32'd42});
        pop_check(1, "t6_and", {2'b00, 32'h0F00_0F00});

        // Randomised traffic with random response backpressure.
        rand_rdy = 1;
        fork
            rand_thread(0, 40);
            rand_thread(1, 40);
        join
        rand_rdy = 0;
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
